// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates two requesters (CPU load/store on port 0, loader/debug
// master on port 1) onto the single-port data memory. A winning command is latched
// in IDLE, presented to the memory for exactly one ACCESS cycle, and read data is
// returned through per-port registers one cycle later.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,

    // Port 0: CPU load/store path
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    // Port 1: loader/debug master
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    // Data memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [15:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,

    output logic              busy
);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e            state_q, state_d;

    // Port that owns the current/most recent access (0 or 1).
    logic              winner_q, winner_d;
    // Round-robin history: the port granted most recently.
    logic              last_q, last_d;

    // Latched command presented to the memory during ACCESS.
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

    // Read return registers.
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    // Port chosen if an arbitration happens this cycle.
    logic              pick;

    // Arbitration: single requester wins outright; ties go to port 0 in fixed mode,
    // otherwise to the port that was not granted last.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            pick = req1;
        end
    end

    // Next-state logic: IDLE latches the winning command, ACCESS always lasts one cycle.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        last_d      = last_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d     = StAccess;
                    winner_d    = pick;
                    last_d      = pick;
                    cmd_we_d    = pick ? we1    : we0;
                    cmd_addr_d  = pick ? addr1  : addr0;
                    cmd_wdata_d = pick ? wdata1 : wdata0;
                end
            end
            StAccess: begin
                // Requests arriving now are only sampled once back in IDLE.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            winner_q    <= 1'b0;
            last_q      <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            last_q      <= last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    // Outputs decoded from state and latched command only; no path from req to gnt.
    always_comb begin
        busy        = (state_q == StAccess);
        gnt0        = busy & ~winner_q;
        gnt1        = busy &  winner_q;
        mem_write   = busy &  cmd_we_q;
        mem_read    = busy & ~cmd_we_q;
        mem_addr    = '0;
        mem_addr[ADDR_W-1:0] = cmd_addr_q;
        mem_wr_data = cmd_wdata_q;
    end

    // Read return: capture memory data at the end of a read ACCESS; reset aborts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= mem_read & ~winner_q;
            rvalid1_q <= mem_read &  winner_q;
            if (mem_read && !winner_q) begin
                rdata0_q <= mem_rd_data;
            end
            if (mem_read && winner_q) begin
                rdata1_q <= mem_rd_data;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

    // Structural invariants of the arbiter.
    a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
        !(mem_read && mem_write));
    a_gnt_excl: assert property (@(posedge clk) disable iff (reset)
        !(gnt0 && gnt1));
    a_access_one_cycle: assert property (@(posedge clk) disable iff (reset)
        (state_q == StAccess) |=> (state_q == StIdle));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance (index 0) and a fixed-priority
// instance (index 1), each with its own behavioural 64x16 memory.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;

    logic        req0 [2], we0 [2], req1 [2], we1 [2];
    logic [5:0]  addr0 [2], addr1 [2];
    logic [15:0] wdata0 [2], wdata1 [2];
    logic        gnt0 [2], rvalid0 [2], gnt1 [2], rvalid1 [2];
    logic [15:0] rdata0 [2], rdata1 [2];
    logic        mem_read [2], mem_write [2], busy [2];
    logic [15:0] mem_addr [2], mem_wr_data [2], mem_rd_data [2];

    logic        pre_we [2];
    logic [5:0]  pre_addr [2];
    logic [15:0] pre_data [2];

    // Expected memory contents per instance.
    logic [15:0] shadow [2][64];

    int checks;
    int failures;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(6), .DATA_W(16), .FIXED_PRIO(0)) u_dut_rr (
        .clk(clk), .reset(reset),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .gnt0(gnt0[0]), .rvalid0(rvalid0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .gnt1(gnt1[0]), .rvalid1(rvalid1[0]), .rdata1(rdata1[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wr_data(mem_wr_data[0]), .mem_rd_data(mem_rd_data[0]), .busy(busy[0])
    );

    dmem_arbiter #(.ADDR_W(6), .DATA_W(16), .FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .gnt0(gnt0[1]), .rvalid0(rvalid0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .gnt1(gnt1[1]), .rvalid1(rvalid1[1]), .rdata1(rdata1[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wr_data(mem_wr_data[1]), .mem_rd_data(mem_rd_data[1]), .busy(busy[1])
    );

    // Behavioural memories: combinational read, write on the clock edge.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        logic [15:0] m [64];
        always @(posedge clk) begin
            if (pre_we[g]) m[pre_addr[g]] <= pre_data[g];
            else if (mem_write[g]) m[mem_addr[g][5:0]] <= mem_wr_data[g];
        end
        assign mem_rd_data[g] = m[mem_addr[g][5:0]];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input int d, input int p, input logic r, input logic w,
                         input logic [5:0] a, input logic [15:0] v);
        if (p == 0) begin
            req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = v;
        end else begin
            req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = v;
        end
    endtask

    task automatic preload(input int d, input logic [5:0] a, input logic [15:0] v);
        pre_we[d] = 1'b1; pre_addr[d] = a; pre_data[d] = v;
        shadow[d][a] = v;
        tick;
        pre_we[d] = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    // Lone-requester transaction with fixed timing, no checking.
    task automatic issue(input int d, input int p, input logic w, input logic [5:0] a,
                         input logic [15:0] v);
        drive(d, p, 1'b1, w, a, v);
        tick;
        drive(d, p, 1'b0, w, a, v);
        tick;
        tick;
        if (w) shadow[d][a] = v;
    endtask

    task automatic test_reset;
        do_reset;
        for (int d = 0; d < 2; d++) begin
            issue(d, 0, 1'b1, 6'd42, 16'h1234);
            issue(d, 1, 1'b0, 6'd42, 16'h1234);
            issue(d, 0, 1'b0, 6'd42, 16'h1234);
        end
        reset = 1'b1;
        tick;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gnt0[d], gnt1[d], rvalid0[d], rvalid1[d], mem_read[d], mem_write[d],
                 busy[d]} !== 7'b0) begin
                failures++;
                $display("FAIL reset_ctrl[%0d]: got %b want 0000000", d,
                         {gnt0[d], gnt1[d], rvalid0[d], rvalid1[d], mem_read[d],
                          mem_write[d], busy[d]});
            end
            checks++;
            if (mem_addr[d] !== 16'h0) begin
                failures++;
                $display("FAIL reset_mem_addr[%0d]: got %h want 0000", d, mem_addr[d]);
            end
            checks++;
            if (mem_wr_data[d] !== 16'h0) begin
                failures++;
                $display("FAIL reset_mem_wr_data[%0d]: got %h want 0000", d, mem_wr_data[d]);
            end
            checks++;
            if (rdata0[d] !== 16'h0 || rdata1[d] !== 16'h0) begin
                failures++;
                $display("FAIL reset_rdata[%0d]: got %h/%h want 0000/0000", d, rdata0[d],
                         rdata1[d]);
            end
        end
        reset = 1'b0;
        tick;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || gnt0[d] !== 1'b0 || gnt1[d] !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_req[%0d]: busy=%b gnt=%b%b want 0 00", d, busy[d],
                         gnt0[d], gnt1[d]);
            end
        end
    endtask

    task automatic test_write_read;
        drive(0, 0, 1'b1, 1'b1, 6'd5, 16'hA5A5);
        tick;
        checks++;
        if (gnt0[0] !== 1'b1 || gnt1[0] !== 1'b0 || busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL wr_gnt: gnt0=%b gnt1=%b busy=%b want 1 0 1", gnt0[0], gnt1[0],
                     busy[0]);
        end
        checks++;
        if (mem_write[0] !== 1'b1 || mem_read[0] !== 1'b0 || mem_addr[0] !== 16'h0005 ||
            mem_wr_data[0] !== 16'hA5A5) begin
            failures++;
            $display("FAIL wr_bus: we=%b re=%b addr=%h data=%h want 1 0 0005 a5a5",
                     mem_write[0], mem_read[0], mem_addr[0], mem_wr_data[0]);
        end
        shadow[0][5] = 16'hA5A5;
        drive(0, 0, 1'b0, 1'b1, 6'd5, 16'hA5A5);
        tick;
        checks++;
        if (busy[0] !== 1'b0 || rvalid0[0] !== 1'b0) begin
            failures++;
            $display("FAIL wr_no_rvalid: busy=%b rvalid0=%b want 0 0", busy[0], rvalid0[0]);
        end
        drive(0, 0, 1'b1, 1'b0, 6'd5, 16'h0);
        tick;
        checks++;
        if (gnt0[0] !== 1'b1 || mem_read[0] !== 1'b1 || mem_addr[0] !== 16'h0005 ||
            rvalid0[0] !== 1'b0) begin
            failures++;
            $display("FAIL rd_gnt: gnt0=%b re=%b addr=%h rvalid0=%b want 1 1 0005 0",
                     gnt0[0], mem_read[0], mem_addr[0], rvalid0[0]);
        end
        drive(0, 0, 1'b0, 1'b0, 6'd5, 16'h0);
        tick;
        checks++;
        if (rvalid0[0] !== 1'b1 || rdata0[0] !== 16'hA5A5) begin
            failures++;
            $display("FAIL rd_data: rvalid0=%b rdata0=%h want 1 a5a5", rvalid0[0],
                     rdata0[0]);
        end
        tick;
        checks++;
        if (rvalid0[0] !== 1'b0 || rdata0[0] !== 16'hA5A5) begin
            failures++;
            $display("FAIL rd_hold: rvalid0=%b rdata0=%h want 0 a5a5", rvalid0[0],
                     rdata0[0]);
        end
    endtask

    task automatic test_round_robin;
        logic model_last;
        logic w;
        int   ngnt;
        int   wt [2];
        int   nrv [2];
        do_reset;
        preload(0, 6'd1, 16'h1111);
        preload(0, 6'd2, 16'h2222);
        model_last = 1'b1;
        ngnt = 0;
        wt = '{0, 0};
        nrv = '{0, 0};
        drive(0, 0, 1'b1, 1'b0, 6'd1, 16'h0);
        drive(0, 1, 1'b1, 1'b0, 6'd2, 16'h0);
        for (int c = 1; c <= 12; c++) begin
            tick;
            wt[0]++;
            wt[1]++;
            checks++;
            if (gnt0[0] && gnt1[0]) begin
                failures++;
                $display("FAIL rr_double_gnt: cycle %0d got gnt0=1 gnt1=1 want one-hot", c);
            end
            if (gnt0[0] || gnt1[0]) begin
                w = gnt1[0];
                ngnt++;
                checks++;
                if (w !== ~model_last) begin
                    failures++;
                    $display("FAIL rr_order: cycle %0d got port %0d want port %0d", c, w,
                             ~model_last);
                end
                checks++;
                if (wt[w] > 4) begin
                    failures++;
                    $display("FAIL rr_wait: port %0d got %0d cycles want <=4", w, wt[w]);
                end
                wt[w] = 0;
                model_last = w;
            end
            if (rvalid0[0]) begin
                nrv[0]++;
                checks++;
                if (rdata0[0] !== 16'h1111) begin
                    failures++;
                    $display("FAIL rr_rdata0: got %h want 1111", rdata0[0]);
                end
            end
            if (rvalid1[0]) begin
                nrv[1]++;
                checks++;
                if (rdata1[0] !== 16'h2222) begin
                    failures++;
                    $display("FAIL rr_rdata1: got %h want 2222", rdata1[0]);
                end
            end
        end
        checks++;
        if (ngnt != 6 || nrv[0] != 3 || nrv[1] != 3) begin
            failures++;
            $display("FAIL rr_counts: got gnt=%0d rv0=%0d rv1=%0d want 6 3 3", ngnt, nrv[0],
                     nrv[1]);
        end
        drive(0, 0, 1'b0, 1'b0, 6'd1, 16'h0);
        drive(0, 1, 1'b0, 1'b0, 6'd2, 16'h0);
        tick;
        tick;
    endtask

    task automatic test_fixed_prio;
        int   n0;
        int   k;
        logic seen;
        do_reset;
        preload(1, 6'd3, 16'($urandom) | 16'h0001);
        preload(1, 6'd4, 16'($urandom) | 16'h0001);
        drive(1, 0, 1'b1, 1'b0, 6'd3, 16'h0);
        drive(1, 1, 1'b1, 1'b0, 6'd4, 16'h0);
        n0 = 0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            checks++;
            if (gnt1[1] !== 1'b0) begin
                failures++;
                $display("FAIL fp_gnt1: cycle %0d got gnt1=%b want 0", c, gnt1[1]);
            end
            if (gnt0[1]) n0++;
            if (rvalid0[1]) begin
                checks++;
                if (rdata0[1] !== shadow[1][3]) begin
                    failures++;
                    $display("FAIL fp_rdata0: got %h want %h", rdata0[1], shadow[1][3]);
                end
            end
        end
        checks++;
        if (n0 != 4) begin
            failures++;
            $display("FAIL fp_gnt0_count: got %0d want 4", n0);
        end
        drive(1, 0, 1'b0, 1'b0, 6'd3, 16'h0);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 4) begin
            tick;
            k++;
            seen = gnt1[1];
        end
        checks++;
        if (!seen || k != 1) begin
            failures++;
            $display("FAIL fp_port1_after_drop: got seen=%b after %0d cycles want 1 after 1",
                     seen, k);
        end
        drive(1, 1, 1'b0, 1'b0, 6'd4, 16'h0);
        tick;
        checks++;
        if (rvalid1[1] !== 1'b1 || rdata1[1] !== shadow[1][4]) begin
            failures++;
            $display("FAIL fp_rdata1: rvalid1=%b rdata1=%h want 1 %h", rvalid1[1], rdata1[1],
                     shadow[1][4]);
        end
        tick;
    endtask

    task automatic test_addr63;
        drive(0, 1, 1'b1, 1'b1, 6'd63, 16'hFFFF);
        tick;
        checks++;
        if (gnt1[0] !== 1'b1 || mem_write[0] !== 1'b1 || mem_addr[0] !== 16'h003F ||
            mem_wr_data[0] !== 16'hFFFF) begin
            failures++;
            $display("FAIL a63_write: gnt1=%b we=%b addr=%h data=%h want 1 1 003f ffff",
                     gnt1[0], mem_write[0], mem_addr[0], mem_wr_data[0]);
        end
        shadow[0][63] = 16'hFFFF;
        drive(0, 1, 1'b0, 1'b1, 6'd63, 16'hFFFF);
        tick;
        tick;
        drive(0, 0, 1'b1, 1'b0, 6'd63, 16'h0);
        tick;
        checks++;
        if (gnt0[0] !== 1'b1 || mem_read[0] !== 1'b1 || mem_addr[0] !== 16'h003F) begin
            failures++;
            $display("FAIL a63_read: gnt0=%b re=%b addr=%h want 1 1 003f", gnt0[0],
                     mem_read[0], mem_addr[0]);
        end
        drive(0, 0, 1'b0, 1'b0, 6'd63, 16'h0);
        tick;
        checks++;
        if (rvalid0[0] !== 1'b1 || rdata0[0] !== 16'hFFFF) begin
            failures++;
            $display("FAIL a63_rdata: rvalid0=%b rdata0=%h want 1 ffff", rvalid0[0],
                     rdata0[0]);
        end
        tick;
    endtask

    task automatic test_reset_abort;
        preload(0, 6'd10, 16'($urandom) | 16'h0001);
        preload(0, 6'd11, 16'($urandom) | 16'h0001);
        issue(0, 1, 1'b0, 6'd11, 16'h0);
        checks++;
        if (rdata1[0] !== shadow[0][11]) begin
            failures++;
            $display("FAIL abort_pre_rdata1: got %h want %h", rdata1[0], shadow[0][11]);
        end
        // Abort a port 1 read in its ACCESS cycle.
        drive(0, 1, 1'b1, 1'b0, 6'd10, 16'h0);
        tick;
        checks++;
        if (gnt1[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort_gnt1: got %b want 1", gnt1[0]);
        end
        reset = 1'b1;
        drive(0, 1, 1'b0, 1'b0, 6'd10, 16'h0);
        tick;
        checks++;
        if (rvalid1[0] !== 1'b0 || rdata1[0] !== 16'h0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort1_state: rvalid1=%b rdata1=%h busy=%b want 0 0000 0",
                     rvalid1[0], rdata1[0], busy[0]);
        end
        reset = 1'b0;
        drive(0, 0, 1'b1, 1'b0, 6'd10, 16'h0);
        drive(0, 1, 1'b1, 1'b0, 6'd11, 16'h0);
        tick;
        checks++;
        if (gnt0[0] !== 1'b1 || gnt1[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort1_tie: gnt0=%b gnt1=%b want 1 0", gnt0[0], gnt1[0]);
        end
        drive(0, 0, 1'b0, 1'b0, 6'd10, 16'h0);
        drive(0, 1, 1'b0, 1'b0, 6'd11, 16'h0);
        tick;
        tick;
        // Abort a port 0 read: the round-robin history must return to port 1.
        drive(0, 0, 1'b1, 1'b0, 6'd11, 16'h0);
        tick;
        checks++;
        if (gnt0[0] !== 1'b1) begin
            failures++;
            $display("FAIL abort0_gnt0: got %b want 1", gnt0[0]);
        end
        reset = 1'b1;
        drive(0, 0, 1'b0, 1'b0, 6'd11, 16'h0);
        tick;
        checks++;
        if (rvalid0[0] !== 1'b0 || rdata0[0] !== 16'h0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort0_state: rvalid0=%b rdata0=%h busy=%b want 0 0000 0",
                     rvalid0[0], rdata0[0], busy[0]);
        end
        reset = 1'b0;
        drive(0, 0, 1'b1, 1'b0, 6'd10, 16'h0);
        drive(0, 1, 1'b1, 1'b0, 6'd11, 16'h0);
        tick;
        checks++;
        if (gnt0[0] !== 1'b1 || gnt1[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort0_tie: gnt0=%b gnt1=%b want 1 0", gnt0[0], gnt1[0]);
        end
        drive(0, 0, 1'b0, 1'b0, 6'd10, 16'h0);
        drive(0, 1, 1'b0, 1'b0, 6'd11, 16'h0);
        tick;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [15:0] dv;
        logic [15:0] r0;
        a  = 6'($urandom_range(31));
        b  = 6'(32 + $urandom_range(30));
        dv = 16'($urandom);
        preload(0, a, 16'($urandom));
        r0 = shadow[0][a];
        drive(0, 0, 1'b1, 1'b0, a, 16'h0);
        tick;
        checks++;
        if (gnt0[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gnt0: got %b want 1", gnt0[0]);
        end
        drive(0, 0, 1'b0, 1'b0, a, 16'h0);
        tick;
        checks++;
        if (rvalid0[0] !== 1'b1 || rdata0[0] !== r0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_rvalid0: rvalid0=%b rdata0=%h busy=%b want 1 %h 0",
                     rvalid0[0], rdata0[0], busy[0], r0);
        end
        drive(0, 1, 1'b1, 1'b1, b, dv);
        tick;
        checks++;
        if (gnt1[0] !== 1'b1 || mem_write[0] !== 1'b1 || mem_addr[0] !== {10'b0, b} ||
            mem_wr_data[0] !== dv) begin
            failures++;
            $display("FAIL b2b_gnt1: gnt1=%b we=%b addr=%h data=%h want 1 1 %h %h", gnt1[0],
                     mem_write[0], mem_addr[0], mem_wr_data[0], {10'b0, b}, dv);
        end
        shadow[0][b] = dv;
        drive(0, 1, 1'b0, 1'b1, b, dv);
        tick;
        checks++;
        if (rvalid1[0] !== 1'b0 || rdata0[0] !== r0) begin
            failures++;
            $display("FAIL b2b_after: rvalid1=%b rdata0=%h want 0 %h", rvalid1[0], rdata0[0],
                     r0);
        end
        issue(0, 0, 1'b0, b, 16'h0);
        checks++;
        if (rdata0[0] !== dv) begin
            failures++;
            $display("FAIL b2b_readback: got %h want %h", rdata0[0], dv);
        end
    endtask

    // Random two-port traffic against a transaction-level model: serialized access
    // order, shadow memory, tie rule and latency bound.
    task automatic test_random;
        logic        pend [2];
        logic        cw [2];
        logic [5:0]  ca [2];
        logic [15:0] cd [2];
        int          wt [2];
        logic        exp_rv [2];
        logic [15:0] exp_rd [2];
        logic [15:0] hold [2];
        logic        prev_req [2];
        logic        gv [2];
        logic        rvv [2];
        logic [15:0] rdv [2];
        logic        model_last;
        logic        exp_w;
        int          grants;
        for (int a = 0; a < 8; a++) preload(0, 6'(a), 16'($urandom));
        do_reset;
        model_last = 1'b1;
        grants = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; cw[p] = 1'b0; ca[p] = 6'd0; cd[p] = 16'h0; wt[p] = 0;
            exp_rv[p] = 1'b0; exp_rd[p] = 16'h0; hold[p] = 16'h0; prev_req[p] = 1'b0;
        end
        for (int i = 0; i < 400; i++) begin
            gv[0] = gnt0[0];    gv[1] = gnt1[0];
            rvv[0] = rvalid0[0]; rvv[1] = rvalid1[0];
            rdv[0] = rdata0[0];  rdv[1] = rdata1[0];
            checks++;
            if (gv[0] && gv[1]) begin
                failures++;
                $display("FAIL rnd_double_gnt: cycle %0d got both grants want one", i);
            end
            checks++;
            if (busy[0] !== (gv[0] | gv[1])) begin
                failures++;
                $display("FAIL rnd_busy: cycle %0d got %b want %b", i, busy[0], gv[0] | gv[1]);
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (rvv[p] !== exp_rv[p]) begin
                    failures++;
                    $display("FAIL rnd_rvalid%0d: cycle %0d got %b want %b", p, i, rvv[p],
                             exp_rv[p]);
                end
                if (exp_rv[p]) hold[p] = exp_rd[p];
                exp_rv[p] = 1'b0;
                checks++;
                if (rdv[p] !== hold[p]) begin
                    failures++;
                    $display("FAIL rnd_rdata%0d: cycle %0d got %h want %h", p, i, rdv[p],
                             hold[p]);
                end
                if (pend[p]) begin
                    wt[p]++;
                    checks++;
                    if (wt[p] == 5) begin
                        failures++;
                        $display("FAIL rnd_starve%0d: cycle %0d got no gnt after 5 want <=4",
                                 p, i);
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (gv[p]) begin
                    grants++;
                    checks++;
                    if (!pend[p]) begin
                        failures++;
                        $display("FAIL rnd_spurious_gnt%0d: cycle %0d got gnt want none",
                                 p, i);
                    end
                    exp_w = (prev_req[0] && prev_req[1]) ? ~model_last : prev_req[1];
                    checks++;
                    if (1'(p) !== exp_w) begin
                        failures++;
                        $display("FAIL rnd_winner: cycle %0d got port %0d want port %0d", i,
                                 p, exp_w);
                    end
                    checks++;
                    if (mem_addr[0] !== {10'b0, ca[p]} || mem_write[0] !== cw[p] ||
                        mem_read[0] !== ~cw[p]) begin
                        failures++;
                        $display("FAIL rnd_bus: cycle %0d got addr=%h we=%b re=%b want %h %b %b",
                                 i, mem_addr[0], mem_write[0], mem_read[0], {10'b0, ca[p]},
                                 cw[p], ~cw[p]);
                    end
                    if (cw[p]) begin
                        checks++;
                        if (mem_wr_data[0] !== cd[p]) begin
                            failures++;
                            $display("FAIL rnd_wdata: cycle %0d got %h want %h", i,
                                     mem_wr_data[0], cd[p]);
                        end
                        shadow[0][ca[p]] = cd[p];
                    end else begin
                        exp_rv[p] = 1'b1;
                        exp_rd[p] = shadow[0][ca[p]];
                    end
                    checks++;
                    if (wt[p] > 4) begin
                        failures++;
                        $display("FAIL rnd_latency%0d: got %0d cycles want <=4", p, wt[p]);
                    end
                    model_last = 1'(p);
                    pend[p] = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(1) == 1) begin
                    pend[p] = 1'b1;
                    wt[p] = 0;
                    cw[p] = 1'($urandom_range(1));
                    ca[p] = 6'($urandom_range(7));
                    cd[p] = 16'($urandom);
                end
                drive(0, p, pend[p], cw[p], ca[p], cd[p]);
                prev_req[p] = pend[p];
            end
            tick;
        end
        drive(0, 0, 1'b0, 1'b0, 6'd0, 16'h0);
        drive(0, 1, 1'b0, 1'b0, 6'd0, 16'h0);
        tick;
        tick;
        tick;
        checks++;
        if (grants < 50) begin
            failures++;
            $display("FAIL rnd_activity: got %0d grants want >=50", grants);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            drive(d, 0, 1'b0, 1'b0, 6'd0, 16'h0);
            drive(d, 1, 1'b0, 1'b0, 6'd0, 16'h0);
            pre_we[d] = 1'b0;
            pre_addr[d] = 6'd0;
            pre_data[d] = 16'h0;
        end
        tick;
        test_reset;
        test_write_read;
        test_round_robin;
        test_fixed_prio;
        test_addr63;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
